// File: rtl/piccolo_dualboot_pkg.sv
// piccolo_dualboot_pkg
// Shared definitions for the dual-boot sequencer:
//   - host op codes
//   - FSM state encoding
//   - default register offsets and the bit positions inside those registers
package piccolo_dualboot_pkg;

  // Host command op codes (cmd_op)
  localparam logic [1:0] OP_STATUS = 2'd0;
  localparam logic [1:0] OP_KICK   = 2'd1;
  localparam logic [1:0] OP_RECONF = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // Default register offsets of the dual-boot IP slave
  localparam int DEF_ADDR_TRIG = 0;
  localparam int DEF_ADDR_SEL  = 1;
  localparam int DEF_ADDR_BUSY = 2;

  // Bit positions inside the registers
  localparam int TRIG_BIT    = 0;  // ADDR_TRIG: trigger reconfiguration
  localparam int WDRST_BIT   = 1;  // ADDR_TRIG: reset watchdog
  localparam int SEL_OVR_BIT = 0;  // ADDR_SEL : config_sel_overwrite
  localparam int SEL_BIT     = 1;  // ADDR_SEL : config_sel (image)
  localparam int BUSY_BIT    = 0;  // ADDR_BUSY: busy

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL_RD,
    S_POLL_WAIT,
    S_SEL_WR,
    S_TRIG_WR,
    S_KICK_WR,
    S_STAT_RD,
    S_STAT_WAIT,
    S_RESP,
    S_HALT
  } state_t;

  // One-hot 32-bit register word with only bit 'pos' set
  function automatic logic [31:0] bit_word(input int pos);
    return 32'(1) << pos;
  endfunction

endpackage

// File: rtl/piccolo_dualboot_kicktimer.sv
// piccolo_dualboot_kicktimer
// Free-running period counter that raises a single kick request every
// KICK_PERIOD cycles. Requests never stack: a wrap while one is already
// pending is absorbed.
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   i_enable       count enable (low once the controller has halted)
//   i_clear        drop the pending request (kick granted)
//   i_restart      restart the period from zero (host kick granted)
//   o_kick_pending one kick waiting for arbitration
module piccolo_dualboot_kicktimer #(
  parameter int KICK_PERIOD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_restart,
  output logic o_kick_pending
);

  localparam logic [31:0] C_WRAP = (KICK_PERIOD > 0) ? 32'(KICK_PERIOD - 1) : 32'd0;

  logic [31:0] r_count;
  logic        r_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_clear)
        r_pending <= 1'b0;
      if (i_restart) begin
        r_count <= '0;
      end else if ((KICK_PERIOD > 0) && i_enable) begin
        if (r_count == C_WRAP) begin
          r_count   <= '0;
          r_pending <= 1'b1;  // a fresh wrap outranks a same-cycle clear
        end else begin
          r_count <= r_count + 32'd1;
        end
      end
    end
  end

  assign o_kick_pending = r_pending;

endmodule

// File: rtl/piccolo_dualboot_ctrl.sv
// piccolo_dualboot_ctrl
// Sequencer in front of the dual-configuration IP Avalon-MM slave. Serialises
// host commands (status, watchdog kick, reconfigure) with periodic auto-kicks,
// busy-polls the IP before every write, one register access at a time.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        host command handshake
//   cmd_op, cmd_image          op code and target image (captured on accept)
//   rsp_valid/rsp_data/rsp_error  one-cycle completion, held data/error
//   triggered                  reconfiguration fired, controller halted
//   avm_*                      Avalon-MM master (no waitrequest, fixed latency)
module piccolo_dualboot_ctrl
  import piccolo_dualboot_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50000000,  // documentation only
  parameter int KICK_PERIOD  = 0,
  parameter int READ_LATENCY = 2,
  parameter int POLL_LIMIT   = 255,
  parameter int ADDR_TRIG    = DEF_ADDR_TRIG,
  parameter int ADDR_SEL     = DEF_ADDR_SEL,
  parameter int ADDR_BUSY    = DEF_ADDR_BUSY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_image,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        triggered,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam logic [1:0] C_WAIT_LAST  = 2'(READ_LATENCY - 1);
  localparam logic [7:0] C_POLL_LIMIT = 8'(POLL_LIMIT);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_op;
  logic        r_image;
  logic        r_is_host;       // current operation came from the host
  logic        r_last_was_host;
  logic [1:0]  r_wait;
  logic [7:0]  r_poll_cnt;
  logic [31:0] r_rsp_data;
  logic        r_rsp_error;
  logic        r_triggered;

  logic        w_kick_pending;
  logic        w_grant_host;
  logic        w_grant_kick;
  logic        w_sample;
  logic [7:0]  w_poll_inc;
  logic        w_rsp_load;
  logic        w_rsp_err_next;
  logic [31:0] w_rsp_data_next;
  logic        w_host_kick;

  // A host kick does the auto-kick's job, so it also resets the period.
  assign w_host_kick = w_grant_host && (cmd_op == OP_KICK);

  piccolo_dualboot_kicktimer #(
    .KICK_PERIOD(KICK_PERIOD)
  ) u_kicktimer (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (r_state != S_HALT),
    .i_clear       (w_grant_kick || w_host_kick),
    .i_restart     (w_host_kick),
    .o_kick_pending(w_kick_pending)
  );

  always_comb begin
    w_state_next    = r_state;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    avm_address     = '0;
    avm_read        = 1'b0;
    avm_write       = 1'b0;
    avm_writedata   = '0;
    w_grant_host    = 1'b0;
    w_grant_kick    = 1'b0;
    w_rsp_load      = 1'b0;
    w_rsp_err_next  = 1'b0;
    w_rsp_data_next = '0;
    w_sample        = (r_wait == C_WAIT_LAST);
    w_poll_inc      = (r_poll_cnt == 8'hFF) ? r_poll_cnt : r_poll_cnt + 8'd1;

    unique case (r_state)
      S_IDLE: begin
        // Pending kick yields to the host only if the host was not served last.
        if (w_kick_pending && (!cmd_valid || r_last_was_host)) begin
          w_grant_kick = 1'b1;
          w_state_next = S_POLL_RD;
        end else if (cmd_valid) begin
          w_grant_host = 1'b1;
          cmd_ready    = !reset;
          unique case (cmd_op)
            OP_STATUS: w_state_next = S_STAT_RD;
            OP_KICK,
            OP_RECONF: w_state_next = S_POLL_RD;
            default: begin
              w_state_next   = S_RESP;
              w_rsp_load     = 1'b1;
              w_rsp_err_next = 1'b1;
            end
          endcase
        end
      end
      S_POLL_RD: begin
        avm_read     = 1'b1;
        avm_address  = 3'(ADDR_BUSY);
        w_state_next = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (w_sample) begin
          if (!avm_readdata[BUSY_BIT]) begin
            w_state_next = (r_op == OP_RECONF) ? S_SEL_WR : S_KICK_WR;
          end else if (w_poll_inc >= C_POLL_LIMIT) begin
            w_state_next   = S_RESP;
            w_rsp_load     = r_is_host;
            w_rsp_err_next = 1'b1;
          end else begin
            w_state_next = S_POLL_RD;
          end
        end
      end
      S_SEL_WR: begin
        avm_write     = 1'b1;
        avm_address   = 3'(ADDR_SEL);
        avm_writedata = bit_word(SEL_OVR_BIT) | (r_image ? bit_word(SEL_BIT) : 32'd0);
        w_state_next  = S_TRIG_WR;
      end
      S_TRIG_WR: begin
        avm_write     = 1'b1;
        avm_address   = 3'(ADDR_TRIG);
        avm_writedata = bit_word(TRIG_BIT);
        w_state_next  = S_RESP;
        w_rsp_load    = r_is_host;
      end
      S_KICK_WR: begin
        avm_write     = 1'b1;
        avm_address   = 3'(ADDR_TRIG);
        avm_writedata = bit_word(WDRST_BIT);
        w_state_next  = S_RESP;
        w_rsp_load    = r_is_host;
      end
      S_STAT_RD: begin
        avm_read     = 1'b1;
        avm_address  = 3'(ADDR_BUSY);
        w_state_next = S_STAT_WAIT;
      end
      S_STAT_WAIT: begin
        if (w_sample) begin
          w_state_next    = S_RESP;
          w_rsp_load      = 1'b1;
          w_rsp_data_next = avm_readdata;
        end
      end
      S_RESP: begin
        rsp_valid    = r_is_host;  // auto-kicks complete silently
        w_state_next = r_triggered ? S_HALT : S_IDLE;
      end
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_op            <= OP_STATUS;
      r_image         <= 1'b0;
      r_is_host       <= 1'b0;
      r_last_was_host <= 1'b0;
      r_wait          <= '0;
      r_poll_cnt      <= '0;
      r_rsp_data      <= '0;
      r_rsp_error     <= 1'b0;
      r_triggered     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_host) begin
        r_op            <= cmd_op;
        r_image         <= cmd_image;
        r_is_host       <= 1'b1;
        r_last_was_host <= 1'b1;
        r_poll_cnt      <= '0;
      end else if (w_grant_kick) begin
        r_op            <= OP_KICK;
        r_is_host       <= 1'b0;
        r_last_was_host <= 1'b0;
        r_poll_cnt      <= '0;
      end
      if ((r_state == S_POLL_RD) || (r_state == S_STAT_RD))
        r_wait <= '0;
      else if ((r_state == S_POLL_WAIT) || (r_state == S_STAT_WAIT))
        r_wait <= r_wait + 2'd1;
      if ((r_state == S_POLL_WAIT) && w_sample && avm_readdata[BUSY_BIT])
        r_poll_cnt <= w_poll_inc;
      if (w_rsp_load) begin
        r_rsp_data  <= w_rsp_data_next;
        r_rsp_error <= w_rsp_err_next;
      end
      if (r_state == S_TRIG_WR)
        r_triggered <= 1'b1;
    end
  end

  assign rsp_data  = r_rsp_data;
  assign rsp_error = r_rsp_error;
  assign triggered = r_triggered;

endmodule

// File: doc/piccolo_dualboot_ctrl.md
Name: piccolo_dualboot_ctrl

Overview:
- Sequencer in front of the dual-configuration (dual image boot) IP's Avalon-MM slave.
- Serialises host commands (status read, watchdog kick, reconfigure into image 0/1) with an internal periodic watchdog-kick timer.
- Busy-polls the IP before every write and issues register accesses one at a time.
- Sits between the host-communication bridge and the dual-boot IP instance in the board top.

Parameters:
- CLOCK_FREQ, 50000000, clk frequency in Hz (documentation only).
- KICK_PERIOD, 0, cycles between automatic watchdog kicks; 0 disables auto-kick.
- READ_LATENCY, 2, fixed slave read latency in cycles (1..4).
- POLL_LIMIT, 255, maximum busy-poll reads before the command aborts with an error.
- ADDR_TRIG, 0, register offset: bit0 = trigger reconfig, bit1 = reset watchdog.
- ADDR_SEL, 1, register offset: bit0 = config_sel_overwrite, bit1 = config_sel.
- ADDR_BUSY, 2, register offset: bit0 = busy.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  command accepted this cycle
- cmd_op  in  2  0 = status read, 1 = watchdog kick, 2 = reconfigure, 3 = reserved
- cmd_image  in  1  target image for reconfigure
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  readdata of the final status read (0 for kick/reconfig)
- rsp_error  out  1  poll timeout or reserved op, qualified by rsp_valid
- triggered  out  1  reconfig trigger written; controller halted
- avm_address  out  3  slave address
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data

Behaviour:
- Reset: all outputs 0; FSM = IDLE; kick timer = 0; kick_pending = 0; last_was_host = 0.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Avalon-MM strobes:
  - avm_read and avm_write are single-cycle and mutually exclusive.
  - There is no waitrequest.
  - Read data is sampled exactly READ_LATENCY cycles after the avm_read cycle.
- States: IDLE, POLL_RD, POLL_WAIT, SEL_WR, TRIG_WR, KICK_WR, STAT_RD, STAT_WAIT, RESP, HALT.
- Acceptance:
  - cmd_ready = 1 only in IDLE when the host wins arbitration.
  - A command is accepted on the cycle cmd_valid and cmd_ready are both 1.
  - cmd_op and cmd_image are captured on that cycle.
- Arbitration in IDLE:
  - Host command and kick_pending both present: kick wins if last_was_host = 1, otherwise host wins.
  - Only one present: it wins.
  - An auto-kick does not generate rsp_valid.
  - last_was_host is updated on each grant.
- Op 3 (reserved): accepted; RESP with rsp_error = 1 on the next cycle; no bus access.
- Op 0 (status read): STAT_RD (avm_read, address ADDR_BUSY) -> STAT_WAIT (READ_LATENCY cycles) -> RESP with rsp_data = readdata.
- Op 1 and auto-kick: busy poll, then KICK_WR writes ADDR_TRIG with data 0x2.
- Op 2 (reconfigure): busy poll, then SEL_WR writes ADDR_SEL with {cmd_image, 1'b1} (data = 0x1 or 0x3), then TRIG_WR writes ADDR_TRIG with data 0x1 on the next cycle.
  - Reconfig with no poll timeout: TRIG_WR -> RESP -> HALT. rsp_valid fires once; triggered = 1 from RESP onward.
  - Reconfig when the poll timed out: normal abort path (RESP with rsp_error = 1, back to IDLE); TRIG_WR is not reached and triggered stays 0.
- HALT: terminal. cmd_ready stays 0 and auto-kicks stop; only reset exits.
- Busy poll:
  - POLL_RD issues a read of ADDR_BUSY; POLL_WAIT waits READ_LATENCY cycles and checks bit0.
  - bit0 = 0: proceed. bit0 = 1: back to POLL_RD with poll count + 1.
  - Poll count (8 bits, saturating) reaching POLL_LIMIT with busy still 1 aborts: RESP with rsp_error = 1 (rsp_valid suppressed for auto-kick), then IDLE.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_data and rsp_error hold until the next RESP.
- Kick timer:
  - Counts while KICK_PERIOD != 0 and FSM != HALT.
  - At KICK_PERIOD-1 it wraps to 0 and sets kick_pending.
  - kick_pending is cleared when a kick is granted.
  - A wrap while kick_pending is already set is absorbed; kicks never queue beyond 1.
- A host op-1 grant also clears kick_pending and restarts the timer.
- Reset mid-operation: strobes drop asynchronously; no partial write sequence resumes. Only SEL_WR without TRIG_WR can result, which is harmless.

Decomposition:
- Shared package piccolo_dualboot_pkg:
  - op codes (OP_STATUS, OP_KICK, OP_RECONF), FSM state encoding;
  - register offsets and bit positions (TRIG_BIT, WDRST_BIT, SEL_OVR_BIT, SEL_BIT, BUSY_BIT).
- Sub-module piccolo_dualboot_kicktimer (period counter plus kick_pending flag, clear input) keeps the FSM module focused on sequencing.

Test Plan:
- Status read: cmd_op = 0, avm_readdata = 0x00000000 -> avm_read at ADDR_BUSY once; rsp_valid 1 + READ_LATENCY + 1 cycles after acceptance; rsp_data = 0, rsp_error = 0.
- Reconfig image 1: slave busy = 1 for 3 polls, then 0 -> 4 reads; write ADDR_SEL = 0x3; next cycle write ADDR_TRIG = 0x1; single rsp_valid; triggered = 1; later cmd_valid never sees cmd_ready.
- Poll timeout: POLL_LIMIT = 4, busy stuck at 1, cmd_op = 1 -> exactly 4 reads, no write, rsp_valid with rsp_error = 1, FSM back in IDLE.
- Auto-kick arbitration: KICK_PERIOD = 100, host issues back-to-back status reads -> writes of 0x2 to ADDR_TRIG interleave with at most one host command between grants; no rsp_valid for auto-kicks.
- Reserved op 3 -> rsp_valid with rsp_error = 1 one cycle after acceptance; no avm_read or avm_write.
- Reset asserted during POLL_WAIT of a reconfig -> all outputs 0 immediately; after release, no write is issued unless a new command arrives.
